// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each client may take up to its weight in
// consecutive grants before priority rotates to the next requester.
module wrr_arbiter #(
   parameter int MAX_THRESH   = 16,
   parameter int CLIENTS      = 4,
   parameter int WAIT_GNT_ACK = 0,
   localparam int MTW = $clog2(MAX_THRESH),
   localparam int N   = $clog2(CLIENTS)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_block_arb,
   input  logic [CLIENTS*MTW-1:0] i_max_thresh,
   input  logic [CLIENTS-1:0]     i_req,
   output logic                   ow_gnt_valid,
   output logic [CLIENTS-1:0]     ow_gnt,
   output logic [N:0]             ow_gnt_id,
   input  logic [CLIENTS-1:0]     i_gnt_ack
);

   logic [N-1:0]       ptr;
   logic [MTW-1:0]     cnt;
   logic               gnt_valid;
   logic [CLIENTS-1:0] gnt;
   logic [N:0]         gnt_id;

   logic [MTW-1:0]     w_last;
   logic               keep;
   logic               found;
   logic [N-1:0]       scan_id;
   logic               win_valid;
   logic [N-1:0]       win_id;
   logic [MTW-1:0]     win_cnt;

   always_comb begin
      w_last = i_max_thresh[int'(ptr)*MTW +: MTW];
      if (w_last == '0)
         w_last = MTW'(1);
   end

   // cnt == 0 only after reset, so the reset pointer never claims a free re-grant.
   assign keep = i_req[ptr] && (cnt != '0) && (cnt < w_last);

   always_comb begin
      found   = 1'b0;
      scan_id = '0;
      for (int k = 1; k <= CLIENTS; k++) begin
         if (!found && i_req[(int'(ptr) + k) % CLIENTS]) begin
            found   = 1'b1;
            scan_id = N'((int'(ptr) + k) % CLIENTS);
         end
      end
   end

   assign win_valid = keep || found;
   assign win_id    = keep ? ptr : scan_id;
   assign win_cnt   = keep ? cnt + MTW'(1) : MTW'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gnt_valid <= 1'b0;
         gnt       <= '0;
         gnt_id    <= '0;
         ptr       <= N'(CLIENTS - 1);
         cnt       <= '0;
      end else if ((WAIT_GNT_ACK != 0) && gnt_valid) begin
         // held grant: only the grantee's ack releases it
         if (i_gnt_ack[gnt_id[N-1:0]]) begin
            gnt_valid <= 1'b0;
            gnt       <= '0;
            gnt_id    <= '0;
         end
      end else if (!i_block_arb && win_valid) begin
         gnt_valid <= 1'b1;
         gnt       <= {{(CLIENTS-1){1'b0}}, 1'b1} << win_id;
         gnt_id    <= {1'b0, win_id};
         ptr       <= win_id;
         cnt       <= win_cnt;
      end else begin
         gnt_valid <= 1'b0;
         gnt       <= '0;
         gnt_id    <= '0;
      end
   end

   assign ow_gnt_valid = gnt_valid;
   assign ow_gnt       = gnt;
   assign ow_gnt_id    = gnt_id;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: a vector table on a 4-client re-arbitrating
// instance plus hand sequences on 2-client ack-hold and weighted instances.
module tb_wrr_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // instance A: 4 clients, no ack hold
   logic        a_rst = 1'b1, a_block = 1'b0;
   logic [15:0] a_thr = 16'h1111;
   logic [3:0]  a_req = '0, a_ack = '0;
   logic        a_valid;
   logic [3:0]  a_gnt;
   logic [2:0]  a_id;

   // instance B: 2 clients, hold until ack
   logic        b_rst = 1'b1, b_block = 1'b0;
   logic [7:0]  b_thr = 8'h00;
   logic [1:0]  b_req = '0, b_ack = '0;
   logic        b_valid;
   logic [1:0]  b_gnt;
   logic [1:0]  b_id;

   // instance C: 2 clients, no ack hold, weighted
   logic        c_rst = 1'b1, c_block = 1'b0;
   logic [7:0]  c_thr = 8'h12;
   logic [1:0]  c_req = '0, c_ack = '0;
   logic        c_valid;
   logic [1:0]  c_gnt;
   logic [1:0]  c_id;

   wrr_arbiter #(.MAX_THRESH(16), .CLIENTS(4), .WAIT_GNT_ACK(0)) dut_a (
      .i_clk(clk), .i_rst(a_rst), .i_block_arb(a_block), .i_max_thresh(a_thr),
      .i_req(a_req), .ow_gnt_valid(a_valid), .ow_gnt(a_gnt), .ow_gnt_id(a_id),
      .i_gnt_ack(a_ack));

   wrr_arbiter #(.MAX_THRESH(16), .CLIENTS(2), .WAIT_GNT_ACK(1)) dut_b (
      .i_clk(clk), .i_rst(b_rst), .i_block_arb(b_block), .i_max_thresh(b_thr),
      .i_req(b_req), .ow_gnt_valid(b_valid), .ow_gnt(b_gnt), .ow_gnt_id(b_id),
      .i_gnt_ack(b_ack));

   wrr_arbiter #(.MAX_THRESH(16), .CLIENTS(2), .WAIT_GNT_ACK(0)) dut_c (
      .i_clk(clk), .i_rst(c_rst), .i_block_arb(c_block), .i_max_thresh(c_thr),
      .i_req(c_req), .ow_gnt_valid(c_valid), .ow_gnt(c_gnt), .ow_gnt_id(c_id),
      .i_gnt_ack(c_ack));

   typedef struct packed {
      logic        rst;
      logic        block;
      logic [3:0]  req;
      logic [15:0] thr;
      logic        ev;
      logic [3:0]  eg;
      logic [2:0]  eid;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_b(input string name, input int ev, input int eid);
      chk({name, " valid"}, int'(b_valid), ev);
      chk({name, " id"},    int'(b_id),    eid);
      chk({name, " gnt"},   int'(b_gnt),   ev ? (1 << eid) : 0);
   endtask

   task automatic chk_c(input string name, input int eid);
      chk({name, " valid"}, int'(c_valid), 1);
      chk({name, " id"},    int'(c_id),    eid);
      chk({name, " gnt"},   int'(c_gnt),   1 << eid);
   endtask

   int seq_w [6] = '{0, 0, 1, 0, 0, 1};
   int seq_z [4] = '{0, 1, 0, 1};

   initial begin
      //          rst  blk  req      thr       ev  eg       eid
      vecs[0]  = '{1'b1, 1'b0, 4'b1111, 16'h1111, 1'b0, 4'b0000, 3'd0};
      vecs[1]  = '{1'b1, 1'b0, 4'b1111, 16'h1111, 1'b0, 4'b0000, 3'd0};
      vecs[2]  = '{1'b0, 1'b0, 4'b1111, 16'h1111, 1'b1, 4'b0001, 3'd0};
      vecs[3]  = '{1'b0, 1'b0, 4'b0000, 16'h1111, 1'b0, 4'b0000, 3'd0};
      vecs[4]  = '{1'b0, 1'b1, 4'b0100, 16'h1111, 1'b0, 4'b0000, 3'd0};
      vecs[5]  = '{1'b0, 1'b1, 4'b0100, 16'h1111, 1'b0, 4'b0000, 3'd0};
      vecs[6]  = '{1'b0, 1'b1, 4'b0100, 16'h1111, 1'b0, 4'b0000, 3'd0};
      vecs[7]  = '{1'b0, 1'b0, 4'b0100, 16'h1111, 1'b1, 4'b0100, 3'd2};
      vecs[8]  = '{1'b0, 1'b0, 4'b1000, 16'h1111, 1'b1, 4'b1000, 3'd3};
      vecs[9]  = '{1'b0, 1'b0, 4'b0101, 16'h1111, 1'b1, 4'b0001, 3'd0};
      vecs[10] = '{1'b0, 1'b0, 4'b0101, 16'h1111, 1'b1, 4'b0100, 3'd2};
      vecs[11] = '{1'b0, 1'b0, 4'b0101, 16'h1111, 1'b1, 4'b0001, 3'd0};
      vecs[12] = '{1'b1, 1'b0, 4'b0101, 16'h1111, 1'b0, 4'b0000, 3'd0};
      vecs[13] = '{1'b0, 1'b0, 4'b1111, 16'h1111, 1'b1, 4'b0001, 3'd0};
      // client 2 weight 3, others weight 0 (acts as 1)
      vecs[14] = '{1'b0, 1'b0, 4'b0100, 16'h0300, 1'b1, 4'b0100, 3'd2};
      vecs[15] = '{1'b0, 1'b0, 4'b0101, 16'h0300, 1'b1, 4'b0100, 3'd2};
      vecs[16] = '{1'b0, 1'b0, 4'b0101, 16'h0300, 1'b1, 4'b0100, 3'd2};
      vecs[17] = '{1'b0, 1'b0, 4'b0101, 16'h0300, 1'b1, 4'b0001, 3'd0};
      vecs[18] = '{1'b0, 1'b0, 4'b0101, 16'h0300, 1'b1, 4'b0100, 3'd2};
      vecs[19] = '{1'b0, 1'b1, 4'b0101, 16'h0300, 1'b0, 4'b0000, 3'd0};

      #2;
      for (int i = 0; i < NV; i++) begin
         a_rst   = vecs[i].rst;
         a_block = vecs[i].block;
         a_req   = vecs[i].req;
         a_thr   = vecs[i].thr;
         step();
         chk($sformatf("vec%0d valid", i), int'(a_valid), int'(vecs[i].ev));
         chk($sformatf("vec%0d gnt", i),   int'(a_gnt),   int'(vecs[i].eg));
         chk($sformatf("vec%0d id", i),    int'(a_id),    int'(vecs[i].eid));
      end

      // ack-hold instance
      b_rst = 1'b1; b_req = 2'b10;
      step();
      chk_b("b reset", 0, 0);
      b_rst = 1'b0;
      step();
      chk_b("b first grant", 1, 1);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) b_req = 2'b00;
         step();
         chk_b($sformatf("b hold%0d", i), 1, 1);
      end
      b_ack = 2'b01;
      step();
      chk_b("b wrong ack", 1, 1);
      b_ack = 2'b10;
      step();
      chk_b("b ack clears", 0, 0);
      b_ack = 2'b00; b_req = 2'b10;
      step();
      chk_b("b regrant", 1, 1);
      b_block = 1'b1; b_ack = 2'b10;
      step();
      chk_b("b block ack clears", 0, 0);
      b_ack = 2'b00;
      step();
      chk_b("b blocked", 0, 0);

      // weighted sequence {c1=1, c0=2}, then both weights 0
      c_rst = 1'b1; c_req = 2'b11;
      step();
      c_rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk_c($sformatf("c weighted%0d", i), seq_w[i]);
      end
      c_thr = 8'h00;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_c($sformatf("c zero-weight%0d", i), seq_z[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Weighted round-robin arbiter for CLIENTS requesters. Each client may win up to a programmable number of consecutive grants before priority rotates to the next requester. Grants are registered. Optionally, a grant is held until the grantee acknowledges it. One instance sits per shared target (e.g. per APB slave port in a crossbar) and drives that target's mux select.

Parameters:
MAX_THRESH, 16, upper bound on per-client weight; MTW = $clog2(MAX_THRESH) bits per weight field.
CLIENTS, 4, number of requesters; N = $clog2(CLIENTS).
WAIT_GNT_ACK, 0, 1 = hold grant until i_gnt_ack of the grantee; 0 = re-arbitrate every cycle.

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_rst  input  1  synchronous reset, active-high.
i_block_arb  input  1  when high, no new grant is issued.
i_max_thresh  input  CLIENTS*MTW  per-client weight; client c uses bits [c*MTW +: MTW].
i_req  input  CLIENTS  request per client.
ow_gnt_valid  output  1  a grant is active.
ow_gnt  output  CLIENTS  one-hot grant; all zero when ow_gnt_valid=0.
ow_gnt_id  output  N+1  binary index of grantee; MSB always 0; zero when not valid.
i_gnt_ack  input  CLIENTS  per-client acknowledge; used only when WAIT_GNT_ACK=1.

Behaviour:
- Interface: one clock (i_clk); reset is synchronous and active-high (i_rst).
- State registers: grant valid, grant id, last-winner pointer, and consecutive-grant count (MTW bits).
- Reset: ow_gnt_valid=0, ow_gnt=0, ow_gnt_id=0, count=0, pointer=CLIENTS-1 (client 0 has first priority).
- Weight: w[c] = i_max_thresh slice; a value of 0 is treated as 1. Weights are sampled at each arbitration decision.
- Winner selection (combinational; registered on the next edge):
  - If the last winner L still requests and count < w[L], L wins again and count increments.
  - Otherwise the first requesting client scanning L+1, L+2, ... with wrap-around wins. The pointer becomes that client and count=1.
  - If no client requests, there is no winner and the pointer and count are unchanged.
- Arbitration occurs on an edge when i_block_arb=0 and, if WAIT_GNT_ACK=1, no grant is currently held.
- Latency: a grant appears 1 cycle after the request when idle.
- WAIT_GNT_ACK=1:
  - Grant registers hold while ow_gnt_valid=1 and i_gnt_ack[ow_gnt_id]=0, even if the request drops.
  - When i_gnt_ack[ow_gnt_id]=1, the grant clears at the next edge (ow_gnt_valid=0 for at least 1 cycle). Re-arbitration happens on the following edge.
  - i_gnt_ack bits for non-granted clients are ignored.
- WAIT_GNT_ACK=0:
  - The grant is re-evaluated every edge from the current i_req.
  - If no request is present, or i_block_arb=1, ow_gnt_valid=0 on the next cycle.
  - Each registered grant counts as one consumption.
- i_block_arb=1: no new grant is issued. With WAIT_GNT_ACK=1 an existing grant is still held until acked and then cleared.
- Outputs are driven directly from registers, with no combinational path from inputs to outputs.
- ow_gnt is always exactly one-hot or zero, and is consistent with ow_gnt_id.
- Reset asserted mid-grant returns all state to its reset values on that edge.

Test Plan:
- Reset: assert i_rst 2 cycles with i_req=4'b1111 -> ow_gnt_valid=0, ow_gnt=0, ow_gnt_id=0. First grant after release is client 0.
- WAIT_GNT_ACK=1, CLIENTS=2, i_req=2'b10 held:
  - ow_gnt=2'b10 and ow_gnt_id=1 one cycle later, held 5 cycles with no ack.
  - i_gnt_ack[0]=1 has no effect.
  - i_gnt_ack[1]=1 -> ow_gnt_valid=0 the next cycle.
- WAIT_GNT_ACK=0, CLIENTS=2, thresholds {c1=1, c0=2}, i_req=2'b11 continuous -> grant id sequence 0,0,1,0,0,1.
- Threshold 0 for both clients with both requesting -> strict alternation 0,1,0,1 (0 treated as 1).
- i_block_arb=1 with i_req=4'b0100 for 3 cycles -> no grant. Drop block -> ow_gnt=4'b0100, ow_gnt_id=2 one cycle later.
- Wrap-around: CLIENTS=4, last winner 3, i_req=4'b0101, threshold 1 -> next grants 0, then 2, then 0.
